// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: width encodings, FSM states, MMIO offsets.
// Takes the place of a dmem_defs.vh include so every file picks them up with one import.
package dmem_ctrl_pkg;
  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam int MMIO_HALT_OFS = 0;
  localparam int MMIO_CON_OFS  = 4;
endpackage

// File: rtl/dmem_ctrl_sram.sv
// DEPTH x 32 synchronous single-port array with a per-byte write mask.
// A write-enabled cycle returns the old word on o_rdata.
module dmem_sram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [3:0]               i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready handshake, LATENCY-cycle access, byte/half/word lanes.
// Optional MMIO halt/console decode is built when DMEM_MMIO_EN is defined.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 1,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = 32'h0000_FFF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_width,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_halt_valid,
  output logic [31:0]       o_halt_code,
  output logic              o_con_valid,
  output logic [7:0]        o_con_char
);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_resp_valid;
  logic        r_halt_valid, r_con_valid;
  logic [31:0] r_halt_code;
  logic [7:0]  r_con_char;

  logic [1:0]  r_width_p0, r_ofs_p0;
  logic        r_signed_p0, r_err_p0, r_zero_p0;

  logic              w_accept, w_misalign, w_bypass, w_sram_en;
  logic              w_in_win, w_halt_hit, w_con_hit;
  logic [3:0]        w_mask, w_we;
  logic [31:0]       w_wdata, w_sram_q;
  logic [IDX_W-1:0]  w_idx;

  function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] width,
                                           input logic [1:0] ofs, input logic sgn);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh16;
    logic signed [31:0] ext;
    sh   = word >> {ofs, 3'b000};
    sb   = $signed(sh[7:0]);
    sh16 = $signed(sh[15:0]);
    ext  = $signed(word);
    if (width == W_BYTE)      ext = sgn ? 32'(sb)   : {24'b0, sh[7:0]};
    else if (width == W_HALF) ext = sgn ? 32'(sh16) : {16'b0, sh[15:0]};
    return ext;
  endfunction

  assign w_accept   = i_req_valid && (r_state == S_IDLE) && !rst;
  assign w_misalign = (i_req_width == 2'b11) ||
                      ((i_req_width == W_HALF) && i_req_addr[0]) ||
                      ((i_req_width == W_WORD) && (i_req_addr[1:0] != 2'b00));

`ifdef DMEM_MMIO_EN
  logic [ADDR_W-1:0] w_mmio_ofs;
  // Unsigned offset: addresses below the base wrap to huge values and fall outside the window.
  assign w_mmio_ofs = i_req_addr - MMIO_ADDR;
  assign w_in_win   = (w_mmio_ofs < ADDR_W'(8));
  assign w_halt_hit = i_req_write && !w_misalign && (i_req_width == W_WORD) &&
                      (w_mmio_ofs == ADDR_W'(MMIO_HALT_OFS));
  assign w_con_hit  = i_req_write && !w_misalign && (i_req_width == W_BYTE) &&
                      (w_mmio_ofs == ADDR_W'(MMIO_CON_OFS));
`else
  logic w_unused_bits;
  assign w_unused_bits = ^{MMIO_ADDR, i_req_addr};
  assign w_in_win   = 1'b0;
  assign w_halt_hit = 1'b0;
  assign w_con_hit  = 1'b0;
`endif

  assign w_bypass = w_misalign || w_halt_hit || w_con_hit || (!i_req_write && w_in_win);

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = i_req_wdata;
    if (i_req_width == W_BYTE) begin
      w_mask  = 4'b0001 << i_req_addr[1:0];
      w_wdata = {4{i_req_wdata[7:0]}};
    end else if (i_req_width == W_HALF) begin
      w_mask  = 4'b0011 << {i_req_addr[1], 1'b0};
      w_wdata = {2{i_req_wdata[15:0]}};
    end
  end

  assign w_sram_en = w_accept && !w_bypass;
  assign w_we      = i_req_write ? w_mask : 4'b0000;
  assign w_idx     = i_req_addr[IDX_W+1:2];

  dmem_sram #(.DEPTH(DEPTH)) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_sram_q)
  );

  // p0: request attributes captured on the accept edge, held for the response.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_width_p0  <= i_req_width;
      r_ofs_p0    <= i_req_addr[1:0];
      r_signed_p0 <= i_req_signed;
      r_err_p0    <= w_misalign;
      r_zero_p0   <= i_req_write || w_bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_halt_valid <= 1'b0;
      r_halt_code  <= 32'd0;
      r_con_valid  <= 1'b0;
      r_con_char   <= 8'd0;
    end else begin
      r_halt_valid <= 1'b0;
      r_con_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= CNT_INIT;
            if (LATENCY == 1) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
            if (w_halt_hit) begin
              r_halt_valid <= 1'b1;
              r_halt_code  <= i_req_wdata;
            end
            if (w_con_hit) begin
              r_con_valid <= 1'b1;
              r_con_char  <= i_req_wdata[7:0];
            end
          end
        end
        S_BUSY: begin
          // Leaving on the last count makes resp_valid visible to the consumer LATENCY edges after accept.
          if (r_cnt <= 4'd1) begin
            r_cnt        <= 4'd0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The array port is idle outside IDLE, so its read register holds the load word through RESP.
  assign o_req_ready  = (r_state == S_IDLE);
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_valid && r_err_p0;
  assign o_resp_rdata = (r_resp_valid && !r_zero_p0) ?
                        f_extend(w_sram_q, r_width_p0, r_ofs_p0, r_signed_p0) : 32'd0;
  assign o_halt_valid = r_halt_valid;
  assign o_halt_code  = r_halt_code;
  assign o_con_valid  = r_con_valid;
  assign o_con_char   = r_con_char;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (LATENCY=3, DEPTH=64) against a byte-array reference model.
// Checks the MMIO behaviour matching whether DMEM_MMIO_EN is defined.
module tb_dmem_ctrl;
  localparam int LAT = 3;
  localparam int DEP = 64;
  localparam logic [1:0] BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, RSVD = 2'b11;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, halt_valid, con_valid;
  logic [31:0] resp_rdata, halt_code;
  logic [7:0]  con_char;

  int n_cmp = 0, n_bad = 0;
  int halt_cnt = 0, con_cnt = 0;
  logic [31:0] halt_last = 32'd0;
  logic [7:0]  con_last = 8'd0;
  logic [7:0]  mb [DEP*4];

  typedef struct {
    bit          wr;
    logic [1:0]  w;
    bit          sg;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  dmem_ctrl #(.ADDR_W(32), .DEPTH(DEP), .LATENCY(LAT), .MMIO_ADDR(32'h0000_FFF0)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_width(req_width), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_halt_valid(halt_valid),
    .o_halt_code(halt_code), .o_con_valid(con_valid), .o_con_char(con_char)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (halt_valid) begin halt_cnt++; halt_last = halt_code; end
    if (con_valid)  begin con_cnt++;  con_last  = con_char;  end
  end

  // Reference model: little-endian byte array, DEPTH*4 bytes, addresses wrap.
  function automatic bit f_mis(input logic [1:0] w, input logic [31:0] a);
    return (w == RSVD) || (w == HALF && a[0]) || (w == WORD && a[1:0] != 2'b00);
  endfunction

  task automatic m_access(input bit wr, input logic [1:0] w, input bit sg, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n, base;
    logic [31:0] v;
    rd = 32'd0; er = 1'b0;
    if (f_mis(w, a)) begin er = 1'b1; return; end
    n = (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
    base = int'(a % (DEP*4));
    if (wr) begin
      for (int k = 0; k < n; k++) mb[base+k] = d[8*k +: 8];
      return;
    end
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[base+k]) << (8*k));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    rd = v;
  endtask

  // Drives one request, waits for its response (after `hold` stall cycles), completes the handshake.
  task automatic xact(input bit wr, input logic [1:0] w, input bit sg, input logic [31:0] a,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic er, output int lat, output bit ok);
    int t;
    ok = 1'b1; lat = 0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_width = w; req_signed = sg; req_addr = a; req_wdata = d;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    while (!resp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    if (!resp_valid) begin ok = 1'b0; return; end
    repeat (hold) @(negedge clk);
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", resp_err); end
    n_cmp++;
    if ({halt_valid, con_valid, halt_code, con_char} !== 42'd0) begin
      n_bad++; $display("FAIL reset_mmio got=%b%b %h %h want=0", halt_valid, con_valid, halt_code, con_char);
    end
    rst = 1'b0;
  endtask

  task automatic init_array();
    logic [31:0] rd, d; logic er; int lat; bit ok;
    for (int i = 0; i < DEP; i++) begin
      d = $urandom;
      xact(1'b1, WORD, 1'b0, 32'(i*4), d, 0, rd, er, lat, ok);
      m_access(1'b1, WORD, 1'b0, 32'(i*4), d, rd, er);
      if (!ok) begin n_cmp++; n_bad++; $display("FAIL init_timeout idx=%0d", i); end
    end
  endtask

  task automatic test_directed();
    vec_t tb[$];
    logic [31:0] rd, mrd; logic er, mer; int lat; bit ok;
    tb.push_back('{1'b1, WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    tb.push_back('{1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    tb.push_back('{1'b1, WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0});
    tb.push_back('{1'b1, BYTE, 1'b0, 32'h13, 32'h80, 32'h0, 1'b0});
    tb.push_back('{1'b0, BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0});
    tb.push_back('{1'b0, BYTE, 1'b0, 32'h13, 32'h0, 32'h00000080, 1'b0});
    tb.push_back('{1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h80000000, 1'b0});
    tb.push_back('{1'b0, HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1});
    tb.push_back('{1'b1, WORD, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1});
    tb.push_back('{1'b1, RSVD, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1});
    tb.push_back('{1'b0, WORD, 1'b0, 32'h10, 32'h0, 32'h80000000, 1'b0});
    tb.push_back('{1'b0, HALF, 1'b1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0});
    tb.push_back('{1'b1, HALF, 1'b0, 32'h110, 32'h1234ABCD, 32'h0, 1'b0});
    tb.push_back('{1'b0, WORD, 1'b0, 32'h7FFFF010, 32'h0, 32'h8000ABCD, 1'b0});
    foreach (tb[i]) begin
      xact(tb[i].wr, tb[i].w, tb[i].sg, tb[i].a, tb[i].d, 0, rd, er, lat, ok);
      m_access(tb[i].wr, tb[i].w, tb[i].sg, tb[i].a, tb[i].d, mrd, mer);
      n_cmp++;
      if (!ok || lat != LAT) begin n_bad++; $display("FAIL dir_latency[%0d] got=%0d ok=%0d want=%0d", i, lat, ok, LAT); end
      n_cmp++;
      if (rd !== tb[i].exp_rd || er !== tb[i].exp_er) begin
        n_bad++; $display("FAIL dir_resp[%0d] got=%h/%b want=%h/%b", i, rd, er, tb[i].exp_rd, tb[i].exp_er);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, mrd; logic [1:0] w; bit wr, sg; logic er, mer; int lat; bit ok;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      w  = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a[1:0] = (w == WORD) ? 2'b00 : (w == HALF) ? {a[1], 1'b0} : a[1:0];
      d  = $urandom;
      xact(wr, w, sg, a, d, $urandom_range(0, 3), rd, er, lat, ok);
      m_access(wr, w, sg, a, d, mrd, mer);
      n_cmp++;
      if (!ok || lat != LAT) begin n_bad++; $display("FAIL rnd_latency[%0d] got=%0d ok=%0d want=%0d", i, lat, ok, LAT); end
      n_cmp++;
      if (rd !== mrd || er !== mer) begin
        n_bad++; $display("FAIL rnd_resp[%0d] wr=%0d w=%0d sg=%0d a=%h got=%h/%b want=%h/%b", i, wr, w, sg, a, rd, er, mrd, mer);
      end
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready_back[%0d] got=%b want=1", i, req_ready); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp, rd, mrd; logic er, mer; int t, bad; bit ok; int lat;
    m_access(1'b0, WORD, 1'b0, 32'h10, 32'h0, exp, mer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_width = WORD; req_signed = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b1; req_wdata = 32'h55555555; req_addr = 32'h10;
    t = 0;
    while (!resp_valid && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (!resp_valid) begin n_bad++; $display("FAIL stall_timeout got=0 want=resp_valid"); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL stall_hold bad_cycles=%0d want=0 (rdata=%h want=%h)", bad, resp_rdata, exp); end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release got=%b/%b want=0/1", resp_valid, req_ready);
    end
    xact(1'b0, WORD, 1'b0, 32'h10, 32'h0, 0, rd, er, lat, ok);
    m_access(1'b0, WORD, 1'b0, 32'h10, 32'h0, mrd, mer);
    n_cmp++;
    if (!ok || rd !== mrd) begin n_bad++; $display("FAIL stall_ignored_store got=%h want=%h", rd, mrd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd; logic er, mer; int lat, bad; bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = WORD; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_access(1'b1, WORD, 1'b0, 32'h20, 32'h12345678, mrd, mer);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL rstmid_quiet bad_cycles=%0d want=0", bad); end
    xact(1'b0, WORD, 1'b0, 32'h20, 32'h0, 0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || rd !== 32'h12345678 || er !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_load got=%h/%b want=12345678/0", rd, er);
    end
  endtask

  task automatic test_mmio();
    logic [31:0] rd, mrd; logic er, mer; int lat, h0, c0; bit ok;
    h0 = halt_cnt; c0 = con_cnt;
    xact(1'b1, WORD, 1'b0, 32'hFFF0, 32'h1, 0, rd, er, lat, ok);
    xact(1'b1, BYTE, 1'b0, 32'hFFF4, 32'h41, 0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || lat != LAT) begin n_bad++; $display("FAIL mmio_latency got=%0d want=%0d", lat, LAT); end
`ifdef DMEM_MMIO_EN
    n_cmp++;
    if (halt_cnt - h0 != 1 || halt_last !== 32'h1) begin
      n_bad++; $display("FAIL mmio_halt pulses=%0d code=%h want=1/00000001", halt_cnt - h0, halt_last);
    end
    n_cmp++;
    if (con_cnt - c0 != 1 || con_last !== 8'h41) begin
      n_bad++; $display("FAIL mmio_con pulses=%0d char=%h want=1/41", con_cnt - c0, con_last);
    end
    xact(1'b0, WORD, 1'b0, 32'hFFF0, 32'h0, 0, rd, er, lat, ok);
    n_cmp++;
    if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL mmio_load got=%h/%b want=0/0", rd, er); end
    xact(1'b0, WORD, 1'b0, 32'hF0, 32'h0, 0, rd, er, lat, ok);
    m_access(1'b0, WORD, 1'b0, 32'hF0, 32'h0, mrd, mer);
    n_cmp++;
    if (rd !== mrd) begin n_bad++; $display("FAIL mmio_array_untouched got=%h want=%h", rd, mrd); end
`else
    m_access(1'b1, WORD, 1'b0, 32'hFFF0, 32'h1, mrd, mer);
    m_access(1'b1, BYTE, 1'b0, 32'hFFF4, 32'h41, mrd, mer);
    n_cmp++;
    if (halt_cnt != h0 || con_cnt != c0 || halt_code !== 32'h0 || con_char !== 8'h0) begin
      n_bad++; $display("FAIL mmio_tied pulses=%0d/%0d code=%h char=%h want=0", halt_cnt - h0, con_cnt - c0, halt_code, con_char);
    end
    xact(1'b0, WORD, 1'b0, 32'hFFF0, 32'h0, 0, rd, er, lat, ok);
    m_access(1'b0, WORD, 1'b0, 32'hFFF0, 32'h0, mrd, mer);
    n_cmp++;
    if (rd !== mrd || er !== 1'b0) begin n_bad++; $display("FAIL mmio_array_word got=%h want=%h", rd, mrd); end
    xact(1'b0, BYTE, 1'b0, 32'hFFF4, 32'h0, 0, rd, er, lat, ok);
    n_cmp++;
    if (rd !== 32'h41) begin n_bad++; $display("FAIL mmio_array_byte got=%h want=00000041", rd); end
`endif
  endtask

  initial begin
    test_reset();
    init_array();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    test_mmio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
